ss_piso_transmitter: RTL and testbench

//  Parallel-in/serial-out frame transmitter: the sending end of the single-bit serial

---
 rtl/ss_pkg.sv | 18 +
 rtl/ss_bit_counter.sv | 44 ++++
 rtl/ss_piso_transmitter.sv | 159 +++++++++++++++
 tb/tb_ss_piso_transmitter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared definitions for the serial PISO transmitter: FSM state encodings,
// shift-direction constants and the bit-counter width helper.
package ss_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    // Counter must be able to hold the value WIDTH itself (terminal count).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ss_bit_counter.sv
// Frame bit counter: load-to-1 on frame start, clear at frame end, increments
// while enabled and saturates at WIDTH so it can never wrap.
module ss_bit_counter
    import ss_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic          load_one,
    output logic [CW-1:0] cnt,
    output logic          terminal
);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign terminal = (cnt_reg == CW'(WIDTH));
    assign cnt      = cnt_reg;

    // load_one has priority so a frame start always begins counting from 1.
    always_comb begin
        cnt_next = cnt_reg;
        if (load_one) begin
            cnt_next = CW'(1);
        end else if (clr) begin
            cnt_next = '0;
        end else if (en && !terminal) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/ss_piso_transmitter.sv
// Parallel-in/serial-out frame transmitter: accepts a WIDTH-bit word over
// valid/ready and emits it one bit per enabled clock, MSB- or LSB-first.
module ss_piso_transmitter
    import ss_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             leri,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic             dir_reg;
    logic             dir_next;
    logic             sout_reg;
    logic             sout_next;
    logic             sout_valid_reg;
    logic             sout_valid_next;
    logic             done_reg;
    logic             done_next;
    logic             transfer;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_load_one;
    logic             cnt_terminal;
    logic [CW-1:0]    cnt;

    // Shifted views of the frame register; the bit about to appear at the
    // output end after a shift is the next bit on the wire.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == 0) begin : g_shl_lsb
            assign shl[gi] = 1'b0;
        end else begin : g_shl_up
            assign shl[gi] = shreg_reg[gi-1];
        end
        if (gi == WIDTH - 1) begin : g_shr_msb
            assign shr[gi] = 1'b0;
        end else begin : g_shr_dn
            assign shr[gi] = shreg_reg[gi+1];
        end
    end

    ss_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .load_one (cnt_load_one),
        .cnt      (cnt),
        .terminal (cnt_terminal)
    );

    // rst_n gates ready so no source sees a handshake while held in reset.
    assign load_ready = rst_n & ena & (state_reg == ST_IDLE);
    assign transfer   = load_valid & load_ready;
    assign busy       = (state_reg == ST_SHIFT);
    assign sout       = sout_reg;
    assign sout_valid = sout_valid_reg;
    assign done       = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (transfer) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ena && cnt_terminal) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // done_next defaults low so the pulse self-clears even while ena is low.
    always_comb begin
        shreg_next      = shreg_reg;
        dir_next        = dir_reg;
        sout_next       = sout_reg;
        sout_valid_next = sout_valid_reg;
        done_next       = 1'b0;
        cnt_en          = 1'b0;
        cnt_clr         = 1'b0;
        cnt_load_one    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (transfer) begin
                    shreg_next      = din;
                    dir_next        = leri;
                    sout_next       = (leri == DIR_LSB_FIRST) ? din[0] : din[WIDTH-1];
                    sout_valid_next = 1'b1;
                    cnt_load_one    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ena) begin
                    if (cnt_terminal) begin
                        sout_next       = 1'b0;
                        sout_valid_next = 1'b0;
                        done_next       = 1'b1;
                        cnt_clr         = 1'b1;
                    end else begin
                        shreg_next = (dir_reg == DIR_LSB_FIRST) ? shr : shl;
                        sout_next  = (dir_reg == DIR_LSB_FIRST) ? shr[0] : shl[WIDTH-1];
                        cnt_en     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_reg      <= '0;
            dir_reg        <= DIR_MSB_FIRST;
            sout_reg       <= 1'b0;
            sout_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            shreg_reg      <= shreg_next;
            dir_reg        <= dir_next;
            sout_reg       <= sout_next;
            sout_valid_reg <= sout_valid_next;
            done_reg       <= done_next;
        end
    end

endmodule

// File: tb/tb_ss_piso_transmitter.sv
// Directed self-checking bench for ss_piso_transmitter (WIDTH=8).
module tb_ss_piso_transmitter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             leri;
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    ss_piso_transmitter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .leri       (leri),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at the first negedge after the transfer edge; ends on the done cycle.
    task automatic body_check(input logic [7:0] seq, input int pause_at);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bit%0d_sout", i), sout, seq[7-i]);
            check($sformatf("bit%0d_valid", i), sout_valid, 1);
            check($sformatf("bit%0d_busy", i), busy, 1);
            check($sformatf("bit%0d_done", i), done, 0);
            check($sformatf("bit%0d_ready", i), load_ready, 0);
            if (i == pause_at) begin
                ena = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check($sformatf("hold%0d_sout", k), sout, seq[7-i]);
                    check($sformatf("hold%0d_valid", k), sout_valid, 1);
                    check($sformatf("hold%0d_done", k), done, 0);
                end
                ena = 1'b1;
            end
            step();
        end
        check("end_valid", sout_valid, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_sout", sout, 0);
    endtask

    initial begin
        logic [7:0] rx;
        int         nbits;
        logic       got_done;
        logic       lv;

        rst_n      = 1'b0;
        ena        = 1'b1;
        leri       = 1'b0;
        load_valid = 1'b0;
        din        = '0;
        step();
        step();
        check("rst_sout", sout, 0);
        check("rst_valid", sout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", load_ready, 0);
        rst_n = 1'b1;
        step();
        check("idle_ready", load_ready, 1);

        // ena low in IDLE blocks any transfer
        ena        = 1'b0;
        load_valid = 1'b1;
        din        = 8'hC3;
        #1;
        check("ena_low_ready", load_ready, 0);
        step();
        check("ena_low_busy", busy, 0);
        check("ena_low_valid", sout_valid, 0);
        load_valid = 1'b0;
        ena        = 1'b1;
        step();

        // 1: MSB first, leri flipped after transfer
        $display("frame 1: din=1e leri=0");
        din = 8'h1E; leri = 1'b0; load_valid = 1'b1;
        step();
        load_valid = 1'b0; din = 8'h55; leri = 1'b1;
        body_check(8'b0001_1110, -1);
        step();
        check("f1_done_clear", done, 0);

        // 2: LSB first, leri flipped after transfer
        $display("frame 2: din=1e leri=1");
        din = 8'h1E; leri = 1'b1; load_valid = 1'b1;
        step();
        load_valid = 1'b0; din = 8'h00; leri = 1'b0;
        body_check(8'b0111_1000, -1);
        step();
        check("f2_done_clear", done, 0);

        // 3: ena low for 3 cycles after bit 3
        $display("frame 3: din=a0 leri=0 pause after bit 3");
        din = 8'hA0; leri = 1'b0; load_valid = 1'b1;
        step();
        load_valid = 1'b0; din = 8'hFF;
        body_check(8'b1010_0000, 3);
        step();
        check("f3_done_clear", done, 0);

        // 4: back-to-back with load_valid held high
        $display("frame 4a: din=81 leri=0 load_valid held");
        din = 8'h81; leri = 1'b0; load_valid = 1'b1;
        step();
        din = 8'h7E;
        body_check(8'b1000_0001, -1);
        check("b2b_ready", load_ready, 1);
        step();
        $display("frame 4b: din=7e leri=0 back-to-back");
        din = 8'h00; load_valid = 1'b0;
        body_check(8'b0111_1110, -1);
        step();
        check("f4_done_clear", done, 0);

        // 5: reset mid-frame at bit 5
        $display("frame 5: din=ff leri=0 reset at bit 5");
        din = 8'hFF; leri = 1'b0; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("f5_bit%0d", i), sout, 1);
            step();
        end
        check("f5_bit5", sout, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sout", sout, 0);
        check("abort_valid", sout_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", load_ready, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("abort_nodone%0d", i), done, 0);
            check($sformatf("abort_idle%0d", i), sout_valid, 0);
        end

        // 6: loopback into a serial receiver with matching direction
        for (int d = 0; d < 2; d++) begin
            lv = (d == 0) ? 1'b1 : 1'b0;
            $display("frame 6: din=5a leri=%0b loopback", lv);
            din = 8'h5A; leri = lv; load_valid = 1'b1;
            step();
            load_valid = 1'b0; din = 8'h00; leri = ~lv;
            rx = 8'h00; nbits = 0; got_done = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (done) begin
                    got_done = 1'b1;
                    break;
                end
                if (sout_valid) begin
                    rx = lv ? {sout, rx[7:1]} : {rx[6:0], sout};
                    nbits++;
                end
                step();
            end
            check($sformatf("loop%0d_done", d), got_done, 1);
            check($sformatf("loop%0d_nbits", d), nbits, 8);
            check($sformatf("loop%0d_word", d), rx, 8'h5A);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
